// File: rtl/decoder_rr_scheduler.sv
// Round-robin scheduler sharing a single binary-to-one-hot decoder among 2**k requesters.
// Break-before-make: every release passes through IDLE, so consecutive grants are
// separated by at least one all-zero cycle. A hold timer force-releases a stuck owner and
// locks it out until it drops its request.

// Binary index to one-hot decoder with enable.
module bin2onehot #(
  parameter int unsigned k = 6
) (
  input  logic [k-1:0]    in,
  input  logic            enable,
  output logic [2**k-1:0] out
);

  // Single set bit at position `in` when enabled.
  always_comb begin
    out = '0;
    if (enable) out[in] = 1'b1;
  end

endmodule

module decoder_rr_scheduler #(
  parameter int unsigned k        = 6,
  parameter int unsigned HOLD_MAX = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [2**k-1:0] req,
  input  logic            done_i,
  output logic [k-1:0]    grant_idx,
  output logic            grant_en,
  output logic [2**k-1:0] grant,
  output logic            timeout_o,
  output logic [2**k-1:0] lockout
);

  localparam int unsigned N         = 2**k;
  localparam int unsigned CntW      = (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1);
  localparam bit          TimeoutEn = (HOLD_MAX != 0);
  // Count value on the last permitted grant cycle; unused when the timeout is disabled.
  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_MAX - 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e            state_q, state_d;
  logic [k-1:0]      grant_idx_q, grant_idx_d;
  logic              grant_en_q, grant_en_d;
  logic [k-1:0]      ptr_q, ptr_d;
  logic [CntW-1:0]   hold_cnt_q, hold_cnt_d;
  logic              timeout_q, timeout_d;
  logic [N-1:0]      lockout_q, lockout_d;

  logic [N-1:0]      elig;
  logic              found;
  logic [k-1:0]      winner;
  logic [k-1:0]      cand;

  assign elig = req & ~lockout_q;

  // Scan ptr+1 .. ptr+N (natural k-bit wrap); the first eligible requester wins.
  always_comb begin
    found  = 1'b0;
    winner = ptr_q;
    cand   = '0;
    for (int unsigned o = 1; o <= N; o++) begin
      cand = ptr_q + k'(o);
      if (!found && elig[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Next-state logic for the IDLE/GRANT machine, hold timer and lockout mask.
  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    grant_en_d  = grant_en_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    timeout_d   = 1'b0;
    // A requester that drops its request is forgiven.
    lockout_d   = lockout_q & req;

    case (state_q)
      StIdle: begin
        grant_en_d = 1'b0;
        if (found) begin
          grant_idx_d = winner;
          ptr_d       = winner;
          grant_en_d  = 1'b1;
          hold_cnt_d  = '0;
          state_d     = StGrant;
        end
      end
      StGrant: begin
        if (!req[grant_idx_q] || done_i) begin
          grant_en_d = 1'b0;
          state_d    = StIdle;
        end else if (TimeoutEn && (hold_cnt_q == HoldLast)) begin
          grant_en_d             = 1'b0;
          state_d                = StIdle;
          timeout_d              = 1'b1;
          lockout_d[grant_idx_q] = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + CntW'(1);
        end
      end
      default: begin
        grant_en_d = 1'b0;
        state_d    = StIdle;
      end
    endcase
  end

  // State registers; synchronous reset points the first search at index 0.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= StIdle;
      grant_idx_q <= '0;
      grant_en_q  <= 1'b0;
      ptr_q       <= k'(N - 1);
      hold_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      lockout_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      grant_en_q  <= grant_en_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      timeout_q   <= timeout_d;
      lockout_q   <= lockout_d;
    end
  end

  assign grant_idx = grant_idx_q;
  assign grant_en  = grant_en_q;
  assign timeout_o = timeout_q;
  assign lockout   = lockout_q;

  bin2onehot #(
    .k(k)
  ) u_dec (
    .in    (grant_idx_q),
    .enable(grant_en_q),
    .out   (grant)
  );

endmodule

// File: tb/tb_decoder_rr_scheduler.sv
// Bench for decoder_rr_scheduler (k = 6, hold limit 4): directed scenarios plus a random
// run against a cycle-level behavioural model of the arbitration rules.
module tb_decoder_rr_scheduler;

  localparam int K  = 6;
  localparam int N  = 64;
  localparam int HM = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic         done;
  logic [K-1:0] grant_idx;
  logic         grant_en;
  logic [N-1:0] grant;
  logic         timeout_o;
  logic [N-1:0] lockout;

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  bit           m_busy;
  int           m_idx;
  int           m_last;
  int           m_held;
  bit           m_tmo;
  logic [N-1:0] m_lock;

  decoder_rr_scheduler #(
    .k       (K),
    .HOLD_MAX(HM)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .req      (req),
    .done_i   (done),
    .grant_idx(grant_idx),
    .grant_en (grant_en),
    .grant    (grant),
    .timeout_o(timeout_o),
    .lockout  (lockout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N-1:0] bit_at(input int i);
    logic [N-1:0] one;
    one = 1;
    return one << i;
  endfunction

  function automatic logic [N-1:0] exp_grant();
    return m_busy ? bit_at(m_idx) : '0;
  endfunction

  // Advance the model by one edge using the current inputs, then clock the DUT.
  task automatic tick();
    logic [N-1:0] nl;
    if (rst) begin
      m_busy = 0; m_idx = 0; m_last = N - 1; m_held = 0; m_tmo = 0; m_lock = '0;
    end else begin
      nl    = m_lock & req;
      m_tmo = 0;
      if (m_busy) begin
        m_held++;
        if (!req[m_idx] || done) begin
          m_busy = 0;
        end else if (m_held == HM) begin
          m_busy = 0; m_tmo = 1; nl[m_idx] = 1'b1;
        end
      end else begin
        for (int o = 1; o <= N; o++) begin
          int c;
          c = (m_last + o) % N;
          if (!m_busy && req[c] && !m_lock[c]) begin
            m_busy = 1; m_idx = c; m_last = c; m_held = 0;
          end
        end
      end
      m_lock = nl;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [N-1:0] r);
    rst  = 1'b1;
    req  = r;
    done = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset('0);
    checks++;
    if (grant !== '0 || grant_en !== 1'b0 || grant_idx !== '0 || timeout_o !== 1'b0 ||
        lockout !== '0) begin
      errors++;
      $display("FAIL reset_state: grant=%h en=%b idx=%0d tmo=%b lock=%h, want all zero",
               grant, grant_en, grant_idx, timeout_o, lockout);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (grant !== '0 || grant_en !== 1'b0 || timeout_o !== 1'b0) begin
        errors++;
        $display("FAIL idle_no_req cyc %0d: grant=%h en=%b tmo=%b, want 0 0 0",
                 i, grant, grant_en, timeout_o);
      end
    end
    req = bit_at(0);
    tick();
    checks++;
    if (grant !== bit_at(0) || grant_en !== 1'b1) begin
      errors++;
      $display("FAIL first_grant: grant=%h en=%b, want %h 1", grant, grant_en, bit_at(0));
    end
  endtask

  task automatic test_round_robin();
    int order[6] = '{3, 17, 63, 3, 17, 63};
    do_reset(bit_at(3) | bit_at(17) | bit_at(63));
    foreach (order[j]) begin
      for (int c = 0; c < 2; c++) begin
        tick();
        checks++;
        if (grant !== bit_at(order[j]) || grant_idx !== K'(order[j])) begin
          errors++;
          $display("FAIL rr_grant #%0d cyc %0d: grant=%h idx=%0d, want idx %0d",
                   j, c, grant, grant_idx, order[j]);
        end
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      checks++;
      if (grant !== '0 || timeout_o !== 1'b0) begin
        errors++;
        $display("FAIL rr_gap #%0d: grant=%h tmo=%b, want 0 0", j, grant, timeout_o);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset(bit_at(62));
    tick();
    checks++;
    if (grant !== bit_at(62)) begin
      errors++;
      $display("FAIL wrap_setup: grant=%h, want %h", grant, bit_at(62));
    end
    req  = bit_at(1) | bit_at(62);
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    checks++;
    if (grant !== bit_at(1)) begin
      errors++;
      $display("FAIL wrap_next: grant=%h, want %h", grant, bit_at(1));
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    checks++;
    if (grant !== bit_at(62)) begin
      errors++;
      $display("FAIL wrap_back: grant=%h, want %h", grant, bit_at(62));
    end
  endtask

  task automatic test_timeout();
    do_reset(bit_at(5));
    for (int c = 0; c < HM; c++) begin
      tick();
      checks++;
      if (grant !== bit_at(5) || timeout_o !== 1'b0) begin
        errors++;
        $display("FAIL tmo_hold cyc %0d: grant=%h tmo=%b, want %h 0", c, grant, timeout_o,
                 bit_at(5));
      end
    end
    tick();
    checks++;
    if (grant !== '0 || timeout_o !== 1'b1 || lockout !== bit_at(5)) begin
      errors++;
      $display("FAIL tmo_pulse: grant=%h tmo=%b lock=%h, want 0 1 %h", grant, timeout_o,
               lockout, bit_at(5));
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (grant !== '0 || timeout_o !== 1'b0 || lockout !== bit_at(5)) begin
        errors++;
        $display("FAIL tmo_locked cyc %0d: grant=%h tmo=%b lock=%h, want 0 0 %h", c, grant,
                 timeout_o, lockout, bit_at(5));
      end
    end
    req = '0;
    tick();
    checks++;
    if (lockout !== '0) begin
      errors++;
      $display("FAIL tmo_unlock: lock=%h, want 0", lockout);
    end
    req = bit_at(5);
    tick();
    checks++;
    if (grant !== bit_at(5)) begin
      errors++;
      $display("FAIL tmo_regrant: grant=%h, want %h", grant, bit_at(5));
    end
  endtask

  task automatic test_simultaneous();
    do_reset(bit_at(7));
    for (int c = 0; c < HM; c++) tick();
    checks++;
    if (grant !== bit_at(7)) begin
      errors++;
      $display("FAIL simul_setup: grant=%h, want %h", grant, bit_at(7));
    end
    done = 1'b1;
    req  = '0;
    tick();
    done = 1'b0;
    checks++;
    if (grant !== '0 || timeout_o !== 1'b0 || lockout !== '0) begin
      errors++;
      $display("FAIL simul_release: grant=%h tmo=%b lock=%h, want 0 0 0", grant, timeout_o,
               lockout);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(bit_at(9));
    tick();
    checks++;
    if (grant !== bit_at(9)) begin
      errors++;
      $display("FAIL rstmid_setup: grant=%h, want %h", grant, bit_at(9));
    end
    req = bit_at(0) | bit_at(9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (grant !== '0 || grant_en !== 1'b0 || grant_idx !== '0 || timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_drop: grant=%h en=%b idx=%0d tmo=%b, want 0 0 0 0", grant,
               grant_en, grant_idx, timeout_o);
    end
    tick();
    checks++;
    if (grant !== bit_at(0)) begin
      errors++;
      $display("FAIL rstmid_next: grant=%h, want %h", grant, bit_at(0));
    end
  endtask

  task automatic test_random();
    int pool[8] = '{0, 1, 5, 9, 31, 32, 62, 63};
    do_reset('0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) req[pool[$urandom_range(7)]] ^= 1'b1;
      done = ($urandom_range(5) == 0);
      rst  = ($urandom_range(199) == 0);
      tick();
      checks++;
      if (grant !== exp_grant() || grant_en !== m_busy || grant_idx !== K'(m_idx) ||
          timeout_o !== m_tmo || lockout !== m_lock) begin
        errors++;
        $display("FAIL random cyc %0d: grant=%h en=%b idx=%0d tmo=%b lock=%h, want %h %b %0d %b %h",
                 i, grant, grant_en, grant_idx, timeout_o, lockout, exp_grant(), m_busy,
                 m_idx, m_tmo, m_lock);
      end
      checks++;
      if ($countones(grant) > 1) begin
        errors++;
        $display("FAIL onehot cyc %0d: grant=%h, want popcount <= 1", i, grant);
      end
    end
    rst  = 1'b0;
    done = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    req  = '0;
    done = 1'b0;
    test_reset();
    test_round_robin();
    test_wrap();
    test_timeout();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
